// File: rtl/rr_decode_arbiter_pkg.sv
// Shared constants, FSM state type and one-hot helper for the round-robin decode arbiter.
package rr_decode_arbiter_pkg;
  localparam int N_REQ       = 8;
  localparam int IDX_W       = 3;
  localparam int CODE_EN_BIT = 3;

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bus between requesters (master) and the arbiter (slave).
interface rr_decode_arbiter_if
  import rr_decode_arbiter_pkg::*;
;
  logic [N_REQ-1:0]       req;
  logic [CODE_EN_BIT:0]   code;
  logic [N_REQ-1:0]       grant;
  logic                   busy;

  modport master (output req, input code, grant, busy);
  modport slave  (input req, output code, grant, busy);
endinterface

// File: rtl/rr_decode_arbiter_pick.sv
// Round-robin pick: first set request scanning upward from last_idx+1, last_idx itself checked last.
module rr_pick
  import rr_decode_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_idx_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [IDX_W-1:0] cand;

  // Walk offsets from far to near so the nearest hit overwrites earlier ones.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last_idx_i + IDX_W'(k);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end
endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter driving a 3-to-8 decoder code plus registered one-hot grant, bounded tenure.
module rr_decode_arbiter
  import rr_decode_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_decode_arbiter_if.slave bus
);
  localparam int HC_W = $clog2(MAX_HOLD + 1);

  state_e                 state_q;
  logic [HC_W-1:0]        hold_q;
  logic [IDX_W-1:0]       last_q;
  logic [CODE_EN_BIT:0]   code_q;
  logic [N_REQ-1:0]       grant_q;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cur;
  logic                   tenure_end;

  rr_pick u_pick (
    .req_i      (bus.req),
    .last_idx_i (last_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  assign cur        = code_q[IDX_W-1:0];
  assign tenure_end = !bus.req[cur] || (hold_q == HC_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      code_q  <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            state_q <= S_GRANT;
            hold_q  <= HC_W'(1);
            last_q  <= pick_idx;
            code_q  <= {1'b1, pick_idx};
            grant_q <= onehot8(pick_idx);
          end
        end
        S_GRANT: begin
          if (!tenure_end) begin
            hold_q <= hold_q + HC_W'(1);
          end else if (pick_found) begin
            // Hand over on the same edge; no idle bubble between tenures.
            hold_q  <= HC_W'(1);
            last_q  <= pick_idx;
            code_q  <= {1'b1, pick_idx};
            grant_q <= onehot8(pick_idx);
          end else begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            code_q  <= '0;
            grant_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.code  = code_q;
  assign bus.grant = grant_q;
  assign bus.busy  = code_q[CODE_EN_BIT];
endmodule
